// File: rtl/cdc_fifo_write_arbiter_if.sv
// Bundles the two requester handshakes and the FIFO write port seen by the arbiter.
// The master modport is the arbiter's view; the slave modport is the requester/FIFO side.
interface cdc_fifo_write_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  a_valid;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_last;
    logic                  a_ready;
    logic                  b_valid;
    logic [DATA_WIDTH-1:0] b_data;
    logic                  b_last;
    logic                  b_ready;
    logic                  fifo_full;
    logic                  fifo_write_increment;
    logic [DATA_WIDTH-1:0] fifo_write_data;
    logic [1:0]            grant;
    logic [CNT_WIDTH-1:0]  beat_count;

    modport master (
        input  a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_full,
        output a_ready, b_ready, fifo_write_increment, fifo_write_data, grant, beat_count
    );

    modport slave (
        output a_valid, a_data, a_last, b_valid, b_data, b_last, fifo_full,
        input  a_ready, b_ready, fifo_write_increment, fifo_write_data, grant, beat_count
    );
endinterface

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin packet arbiter for the FIFO write port; grant 1 cycle after request, beats pass combinationally.
// Backpressure: owner's ready = !fifo_full, grant held through stalls/gaps, released on last or MAX_BURST.
module cdc_fifo_write_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cdc_fifo_write_arbiter_if.master bus
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } state_e;

    state_e                state_q, state_d;
    logic [BW-1:0]         burst_q, burst_d;
    logic                  last_b_q, last_b_d;   // 1: B was served last
    logic [CNT_WIDTH-1:0]  beat_count_q, beat_count_d;

    logic                  own_a, own_b;
    logic                  a_ready, b_ready;
    logic                  accept_a, accept_b;
    logic                  push;
    logic [DATA_WIDTH-1:0] wr_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            burst_q      <= '0;
            last_b_q     <= 1'b1;
            beat_count_q <= '0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            last_b_q     <= last_b_d;
            beat_count_q <= beat_count_d;
        end
    end

    // Outputs are masked while rst_n is low so nothing is pushed in the reset cycle.
    always_comb begin
        own_a    = rst_n && (state_q == OWN_A);
        own_b    = rst_n && (state_q == OWN_B);
        a_ready  = own_a && !bus.fifo_full;
        b_ready  = own_b && !bus.fifo_full;
        accept_a = a_ready && bus.a_valid;
        accept_b = b_ready && bus.b_valid;
        push     = accept_a || accept_b;
        wr_data  = '0;
        if (own_a) begin
            wr_data = bus.a_data;
        end else if (own_b) begin
            wr_data = bus.b_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        last_b_d     = last_b_q;
        beat_count_d = beat_count_q + CNT_WIDTH'(push);
        case (state_q)
            IDLE: begin
                if (bus.a_valid && (!bus.b_valid || last_b_q)) begin
                    state_d = OWN_A;
                end else if (bus.b_valid) begin
                    state_d = OWN_B;
                end
            end
            OWN_A: begin
                if (accept_a) begin
                    if (bus.a_last || (burst_q == BURST_LAST)) begin
                        last_b_d = 1'b0;
                        burst_d  = '0;
                        state_d  = bus.b_valid ? OWN_B : IDLE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            OWN_B: begin
                if (accept_b) begin
                    if (bus.b_last || (burst_q == BURST_LAST)) begin
                        last_b_d = 1'b1;
                        burst_d  = '0;
                        state_d  = bus.a_valid ? OWN_A : IDLE;
                    end else begin
                        burst_d = burst_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                burst_d = '0;
            end
        endcase
    end

    assign bus.a_ready              = a_ready;
    assign bus.b_ready              = b_ready;
    assign bus.fifo_write_increment = push;
    assign bus.fifo_write_data      = wr_data;
    assign bus.grant                = state_q;
    assign bus.beat_count           = beat_count_q;
endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Directed bench for cdc_fifo_write_arbiter: arbitration order, burst limit, stalls, reset, counter wrap.
module tb_cdc_fifo_write_arbiter;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    cdc_fifo_write_arbiter_if #(.DATA_WIDTH(4), .CNT_WIDTH(8)) bus ();

    cdc_fifo_write_arbiter #(.DATA_WIDTH(4), .MAX_BURST(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b0; bus.a_data = 4'h0; bus.a_last = 1'b0;
        bus.b_valid = 1'b0; bus.b_data = 4'h0; bus.b_last = 1'b0;
        bus.fifo_full = 1'b0;

        // Reset state
        cyc(); cyc();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_a_ready", 32'(bus.a_ready), 32'h0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'h0);
        chk("rst_push", 32'(bus.fifo_write_increment), 32'h0);
        chk("rst_wdata", 32'(bus.fifo_write_data), 32'h0);
        chk("rst_count", 32'(bus.beat_count), 32'h0);

        // A-only 3-beat packet
        rst_n = 1'b1;
        bus.a_valid = 1'b1; bus.a_data = 4'h1;
        #1;
        chk("s1_idle_grant", 32'(bus.grant), 32'h0);
        chk("s1_idle_push", 32'(bus.fifo_write_increment), 32'h0);
        cyc();
        chk("s1_grant_a", 32'(bus.grant), 32'h1);
        chk("s1_push0", 32'(bus.fifo_write_increment), 32'h1);
        chk("s1_data0", 32'(bus.fifo_write_data), 32'h1);
        cyc();
        bus.a_data = 4'h2;
        #1;
        chk("s1_data1", 32'(bus.fifo_write_data), 32'h2);
        chk("s1_push1", 32'(bus.fifo_write_increment), 32'h1);
        cyc();
        bus.a_data = 4'h3; bus.a_last = 1'b1;
        #1;
        chk("s1_data2", 32'(bus.fifo_write_data), 32'h3);
        chk("s1_push2", 32'(bus.fifo_write_increment), 32'h1);
        cyc();
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        #1;
        chk("s1_release", 32'(bus.grant), 32'h0);
        chk("s1_count", 32'(bus.beat_count), 32'h3);

        // Both valid from reset: A first, then direct handoff to B
        rst_n = 1'b0;
        bus.a_valid = 1'b1; bus.a_data = 4'h4;
        bus.b_valid = 1'b1; bus.b_data = 4'hA;
        cyc();
        chk("s2_rst_count", 32'(bus.beat_count), 32'h0);
        rst_n = 1'b1;
        cyc();
        chk("s2_grant_a", 32'(bus.grant), 32'h1);
        chk("s2_b_ready_blk", 32'(bus.b_ready), 32'h0);
        chk("s2_a0", 32'(bus.fifo_write_data), 32'h4);
        cyc();
        bus.a_data = 4'h5; bus.a_last = 1'b1;
        #1;
        chk("s2_a1", 32'(bus.fifo_write_data), 32'h5);
        cyc();
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        #1;
        chk("s2_handoff_b", 32'(bus.grant), 32'h2);
        chk("s2_b_ready", 32'(bus.b_ready), 32'h1);
        chk("s2_a_ready_blk", 32'(bus.a_ready), 32'h0);
        chk("s2_b0", 32'(bus.fifo_write_data), 32'hA);
        cyc();
        bus.b_data = 4'hB; bus.b_last = 1'b1;
        #1;
        chk("s2_b1", 32'(bus.fifo_write_data), 32'hB);
        cyc();
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
        #1;
        chk("s2_release", 32'(bus.grant), 32'h0);
        chk("s2_count", 32'(bus.beat_count), 32'h4);

        // 12-beat A packet against a waiting B: burst limit of 8
        bus.a_valid = 1'b1; bus.a_data = 4'h0;
        bus.b_valid = 1'b1; bus.b_data = 4'hC; bus.b_last = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            bus.a_data = 4'(i);
            #1;
            chk("s3_burst_grant", 32'(bus.grant), 32'h1);
            chk("s3_burst_data", 32'(bus.fifo_write_data), 32'(i));
            cyc();
        end
        chk("s3_limit_to_b", 32'(bus.grant), 32'h2);
        chk("s3_b_data", 32'(bus.fifo_write_data), 32'hC);
        chk("s3_b_push", 32'(bus.fifo_write_increment), 32'h1);
        cyc();
        bus.b_valid = 1'b0; bus.b_last = 1'b0;
        for (int i = 8; i < 12; i++) begin
            bus.a_data = 4'(i);
            bus.a_last = (i == 11);
            #1;
            chk("s3_tail_grant", 32'(bus.grant), 32'h1);
            chk("s3_tail_data", 32'(bus.fifo_write_data), 32'(i));
            cyc();
        end
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        #1;
        chk("s3_release", 32'(bus.grant), 32'h0);
        chk("s3_count", 32'(bus.beat_count), 32'd17);

        // Valid gap and 5-cycle fifo_full stall inside an A packet
        bus.a_valid = 1'b1; bus.a_data = 4'h1;
        cyc();
        chk("s4_push0", 32'(bus.fifo_write_increment), 32'h1);
        cyc();
        bus.a_valid = 1'b0;
        #1;
        chk("s4_gap_grant", 32'(bus.grant), 32'h1);
        chk("s4_gap_ready", 32'(bus.a_ready), 32'h1);
        chk("s4_gap_push", 32'(bus.fifo_write_increment), 32'h0);
        cyc();
        bus.a_valid = 1'b1; bus.a_data = 4'h2; bus.fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("s4_stall_ready", 32'(bus.a_ready), 32'h0);
            chk("s4_stall_push", 32'(bus.fifo_write_increment), 32'h0);
            chk("s4_stall_grant", 32'(bus.grant), 32'h1);
            cyc();
        end
        chk("s4_stall_count", 32'(bus.beat_count), 32'd18);
        bus.fifo_full = 1'b0;
        #1;
        chk("s4_resume_push", 32'(bus.fifo_write_increment), 32'h1);
        chk("s4_resume_data", 32'(bus.fifo_write_data), 32'h2);
        cyc();
        bus.a_data = 4'h3; bus.a_last = 1'b1;
        #1;
        chk("s4_last_data", 32'(bus.fifo_write_data), 32'h3);
        cyc();
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        #1;
        chk("s4_release", 32'(bus.grant), 32'h0);
        chk("s4_count", 32'(bus.beat_count), 32'd20);

        // Reset in the middle of a B packet
        bus.b_valid = 1'b1; bus.b_data = 4'h5;
        cyc();
        chk("s5_grant_b", 32'(bus.grant), 32'h2);
        cyc();
        chk("s5_count_pre", 32'(bus.beat_count), 32'd21);
        bus.b_data = 4'h6; rst_n = 1'b0;
        #1;
        chk("s5_rst_b_ready", 32'(bus.b_ready), 32'h0);
        chk("s5_rst_push", 32'(bus.fifo_write_increment), 32'h0);
        cyc();
        rst_n = 1'b1; bus.a_valid = 1'b1; bus.a_data = 4'h7;
        #1;
        chk("s5_post_grant", 32'(bus.grant), 32'h0);
        chk("s5_post_count", 32'(bus.beat_count), 32'h0);
        chk("s5_post_b_ready", 32'(bus.b_ready), 32'h0);
        cyc();
        chk("s5_tie_a_first", 32'(bus.grant), 32'h1);
        bus.a_last = 1'b1; bus.b_valid = 1'b0;
        cyc();
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        #1;
        chk("s5_release", 32'(bus.grant), 32'h0);
        chk("s5_count", 32'(bus.beat_count), 32'h1);

        // 256 single-beat A packets: beat_count wraps
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        bus.a_valid = 1'b1; bus.a_last = 1'b1; bus.a_data = 4'h9;
        for (int i = 0; i < 510; i++) cyc();
        chk("s6_count_255", 32'(bus.beat_count), 32'd255);
        cyc(); cyc();
        chk("s6_wrap", 32'(bus.beat_count), 32'h0);
        chk("s6_idle_between", 32'(bus.grant), 32'h0);
        bus.a_valid = 1'b0; bus.a_last = 1'b0;
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cdc_fifo_write_arbiter.md
Name: cdc_fifo_write_arbiter

Overview:
- Round-robin arbiter and sequencer for the write port of the 4-bit async FIFO.
- Two requesters, A and B, each present packets of 4-bit beats over valid/ready handshakes.
- The block grants one requester at a time and holds the grant until the packet ends or a burst limit is reached.
- It drives the FIFO write_increment/write_data pair and gates it by the FIFO full flag. clk is used directly as the FIFO write clock.

Parameters:
- DATA_WIDTH, 4, width of a beat and of the FIFO write data.
- MAX_BURST, 8, maximum beats per grant (at least 1).
- CNT_WIDTH, 8, width of the total accepted-beat counter.

Ports:
- clk  input  1  clock; also the FIFO write clock.
- rst_n  input  1  synchronous active-low reset.
- a_valid  input  1  requester A has a beat.
- a_data  input  DATA_WIDTH  requester A beat.
- a_last  input  1  the A beat is the final beat of its packet.
- a_ready  output  1  the A beat is accepted this cycle.
- b_valid  input  1  requester B has a beat.
- b_data  input  DATA_WIDTH  requester B beat.
- b_last  input  1  the B beat is the final beat of its packet.
- b_ready  output  1  the B beat is accepted this cycle.
- fifo_full  input  1  FIFO full flag, write domain.
- fifo_write_increment  output  1  push strobe to the FIFO.
- fifo_write_data  output  DATA_WIDTH  data to the FIFO.
- grant  output  2  00 idle, 01 A owns, 10 B owns; 11 never occurs.
- beat_count  output  CNT_WIDTH  total beats pushed.

Behaviour:
- Reset: applied on clk rising edge while rst_n=0, and it overrides all other activity, including mid-packet.
  - State goes to IDLE, burst counter to 0, beat_count to 0, last_served to B, so A wins the first tie.
  - During and after reset: grant=00, a_ready=b_ready=0, fifo_write_increment=0, fifo_write_data=0.
  - A packet interrupted by reset is abandoned. No partial-packet recovery.
- States: IDLE, OWN_A, OWN_B. grant is the registered state encoding.
- IDLE:
  - If only one valid is high, go to that requester's OWN state on the next edge.
  - If both are high, go to the OWN state of the requester that is not last_served.
  - If neither is high, stay in IDLE.
  - Grant latency is 1 cycle. No beat is accepted in IDLE.
- OWN_x:
  - x_ready = !fifo_full. This is combinational, and x_ready does not depend on x_valid.
  - The other requester's ready = 0.
  - A beat is accepted when x_valid && x_ready.
  - fifo_write_increment = accept, combinational.
  - fifo_write_data = x_data while in OWN_x; otherwise 0.
  - A push is never issued while fifo_full=1.
- Burst counter: counts accepted beats within the current grant. It clears on every grant change.
- Release: occurs on an accepted beat with x_last=1, or on an accepted beat when the burst counter equals MAX_BURST-1.
  - On release, last_served becomes x.
  - If the other requester's valid is high in the release cycle, go directly to OWN_other. There is no bubble.
  - Otherwise go to IDLE. A requester re-requesting with no competition is regranted after one IDLE cycle.
- Grant hold: the grant is held through fifo_full stalls and through x_valid gaps. A packet in progress is never pre-empted except by the MAX_BURST limit.
- MAX_BURST=1: every accepted beat releases the grant.
- beat_count: increments by 1 on each fifo_write_increment and wraps modulo 2^CNT_WIDTH. It is not affected by grant changes.
- Requester rules: requesters hold data and last stable while valid && !ready. The arbiter does not check this.

Test Plan:
- Reset, then A only: a 3-beat packet 0x1, 0x2, 0x3 with last on 0x3.
  - Expect grant=01 one cycle after a_valid rises.
  - Expect 3 consecutive pushes with data 1, 2, 3, then grant=00 and beat_count=3.
- Both valid from reset, each sending a 2-beat packet.
  - Expect A served first, then a direct handoff to B with no idle cycle.
  - Expect push order A0, A1, B0, B1 and beat_count=4.
- A sends a 12-beat packet with no last until beat 12, and B is valid throughout (MAX_BURST=8).
  - Expect 8 A beats, then B's packet, then the remaining 4 A beats.
  - The burst counter restarts at 0 on each grant.
- fifo_full=1 for 5 cycles in the middle of an A packet.
  - Expect a_ready=0 and fifo_write_increment=0 for all 5 cycles, with grant still 01.
  - The push resumes on the cycle fifo_full falls, and no beat is lost or duplicated.
- rst_n=0 for 1 cycle while OWN_B is mid-packet.
  - Expect grant=00, beat_count=0 and b_ready=0 on the next cycle.
  - With A and B then both valid, A is granted first.
- Drive 256 single-beat A packets (CNT_WIDTH=8) -> beat_count wraps to 0.
